// File: rtl/fir_mac_arbiter_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fir_mac_arbiter_if: requester and shared-MAC bus for fir_mac_arbiter    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface fir_mac_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]                 req;
  logic [NUM_REQ-1:0]                 gnt;
  logic [NUM_REQ-1:0]                 op_valid;
  logic [NUM_REQ-1:0]                 op_ready;
  logic [NUM_REQ-1:0]                 op_last;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] op_coeff;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] op_sample;
  logic [DATA_WIDTH-1:0]              mac_a;
  logic [DATA_WIDTH-1:0]              mac_b;
  logic                               mac_valid;
  logic                               mac_first;
  logic                               mac_last;
  logic                               mac_ready;
  logic [DATA_WIDTH-1:0]              mac_res;
  logic                               mac_res_valid;
  logic [DATA_WIDTH-1:0]              res_data;
  logic [NUM_REQ-1:0]                 res_valid;
  logic [1:0]                         err;

  // master: the FIR front-ends plus the MAC; slave: the arbiter itself
  modport master (
    output req, op_valid, op_last, op_coeff, op_sample,
    output mac_ready, mac_res, mac_res_valid,
    input  gnt, op_ready, mac_a, mac_b, mac_valid, mac_first, mac_last,
    input  res_data, res_valid, err
  );

  modport slave (
    input  req, op_valid, op_last, op_coeff, op_sample,
    input  mac_ready, mac_res, mac_res_valid,
    output gnt, op_ready, mac_a, mac_b, mac_valid, mac_first, mac_last,
    output res_data, res_valid, err
  );
endinterface
`default_nettype wire

// File: rtl/fir_mac_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fir_mac_arbiter: round-robin burst arbiter sharing one MAC among FIRs   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module fir_mac_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int MAX_BURST  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  fir_mac_arbiter_if.slave bus
);

  localparam int IDXW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]      op_cnt_q, op_cnt_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [NUM_REQ-1:0]    res_valid_q, res_valid_d;
  logic [1:0]            err_q, err_d;

  logic [NUM_REQ-1:0]    op_ready_w;
  logic                  mac_valid_w;
  logic                  mac_first_w;
  logic                  mac_last_w;
  logic [DATA_WIDTH-1:0] mac_a_w;
  logic [DATA_WIDTH-1:0] mac_b_w;
  logic                  found_w;
  logic [IDXW-1:0]       win_w;
  logic                  xfer_w;
  logic                  at_max_w;
  int                    cand;

  // Rotating search starting just after the last owner
  always_comb begin
    found_w = 1'b0;
    win_w   = ptr_q;
    cand    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr_q) + i) % NUM_REQ;
      if (!found_w && bus.req[IDXW'(cand)]) begin
        found_w = 1'b1;
        win_w   = IDXW'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    op_cnt_d    = op_cnt_q;
    res_data_d  = res_data_q;
    res_valid_d = '0;
    err_d       = err_q;
    op_ready_w  = '0;
    mac_valid_w = 1'b0;
    mac_first_w = 1'b0;
    mac_last_w  = 1'b0;
    mac_a_w     = '0;
    mac_b_w     = '0;
    xfer_w      = 1'b0;
    at_max_w    = (op_cnt_q == CNT_W'(MAX_BURST - 1));

    case (state_q)
      S_IDLE: begin
        if (found_w) begin
          gnt_d    = NUM_REQ'(1) << win_w;
          ptr_d    = win_w;
          op_cnt_d = '0;
          state_d  = S_GRANT;
        end
      end
      S_GRANT: begin
        op_ready_w[ptr_q] = bus.mac_ready;
        xfer_w            = bus.op_valid[ptr_q] && bus.mac_ready;
        if (xfer_w) begin
          mac_valid_w = 1'b1;
          mac_a_w     = bus.op_coeff[ptr_q];
          mac_b_w     = bus.op_sample[ptr_q];
          mac_first_w = (op_cnt_q == '0);
          // A burst that reaches MAX_BURST is closed off even without op_last
          mac_last_w  = bus.op_last[ptr_q] || at_max_w;
          op_cnt_d    = op_cnt_q + CNT_W'(1);
          if (mac_last_w) begin
            state_d = S_DRAIN;
          end
          if (at_max_w && !bus.op_last[ptr_q]) begin
            err_d[0] = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (bus.mac_res_valid) begin
          res_data_d         = bus.mac_res;
          res_valid_d[ptr_q] = 1'b1;
          state_d            = S_RESULT;
        end
      end
      S_RESULT: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.mac_res_valid && (state_q != S_DRAIN)) begin
      err_d[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      ptr_q       <= IDXW'(NUM_REQ - 1);
      op_cnt_q    <= '0;
      res_data_q  <= '0;
      res_valid_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      op_cnt_q    <= op_cnt_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.op_ready  = op_ready_w;
  assign bus.mac_valid = mac_valid_w;
  assign bus.mac_first = mac_first_w;
  assign bus.mac_last  = mac_last_w;
  assign bus.mac_a     = mac_a_w;
  assign bus.mac_b     = mac_b_w;
  assign bus.res_data  = res_data_q;
  assign bus.res_valid = res_valid_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: doc/fir_mac_arbiter.md
Name: fir_mac_arbiter

Overview:
- Shares one multiply-accumulate (MAC) datapath between NUM_REQ decimating FIR filter front-ends, e.g. the L+R and L-R audio channel filters.
- Each requester streams one burst of coefficient×sample operations per output sample.
- The arbiter grants whole bursts round-robin, multiplexes operands into the MAC, waits for the accumulated result and routes it back to the owner.
- It sits between the FIR sample buffers and the shared MAC.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- NUM_REQ, 2, number of requesters (2..8).
- MAX_BURST, 32, maximum operations per burst (equals filter TAPS).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req  in  NUM_REQ  burst request per requester.
- gnt  out  NUM_REQ  registered one-hot grant.
- op_valid  in  NUM_REQ  operand pair valid per requester.
- op_ready  out  NUM_REQ  operand accepted this cycle.
- op_last  in  NUM_REQ  marks final operation of a burst.
- op_coeff  in  NUM_REQ×DATA_WIDTH  coefficient per requester (packed array).
- op_sample  in  NUM_REQ×DATA_WIDTH  sample per requester (packed array).
- mac_a, mac_b  out  DATA_WIDTH  multiplexed operands.
- mac_valid  out  1  operand pair issued to MAC.
- mac_first  out  1  first op of burst; MAC clears accumulator.
- mac_last  out  1  final op of burst.
- mac_ready  in  1  MAC can accept an op.
- mac_res  in  DATA_WIDTH  accumulated, dequantized result.
- mac_res_valid  in  1  result strobe (one cycle).
- res_data  out  DATA_WIDTH  registered result.
- res_valid  out  NUM_REQ  one-cycle result strobe to the owner.
- err  out  2  sticky flags: [0] burst overrun, [1] unexpected result.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: gnt=0, op_ready=0, mac_valid=0, mac_first=0, mac_last=0, mac_a=0, mac_b=0, res_data=0, res_valid=0, err=0. State=IDLE, round-robin pointer ptr=NUM_REQ-1, so requester 0 wins first.
- Reset mid-burst aborts the burst immediately. The MAC must be reset by the same signal.
- States: IDLE, GRANT, DRAIN, RESULT.
- IDLE:
  - req is sampled only in IDLE.
  - If any req bit is set, choose the first set bit searching ptr+1, ptr+2, … modulo NUM_REQ.
  - Next cycle: gnt one-hot to the winner, ptr=winner, op_cnt=0, state=GRANT.
  - Latency req→gnt is 1 cycle. With no req, stay in IDLE.
- GRANT:
  - op_ready[w] = mac_ready. All other op_ready bits are 0.
  - Transfer occurs when op_valid[w] && op_ready[w].
  - On a transfer (combinational, same cycle): mac_valid=1, mac_a=op_coeff[w], mac_b=op_sample[w], mac_first=(op_cnt==0), mac_last=op_last[w] or overrun. Otherwise mac_valid, mac_first and mac_last are 0.
  - op_cnt increments per transfer.
  - A transfer with op_last, or the MAX_BURST-th transfer, moves state to DRAIN.
  - Overrun: the MAX_BURST-th transfer without op_last forces mac_last=1 and sets err[0].
  - op_valid from non-granted requesters is ignored.
  - Deasserting req during a burst has no effect.
- DRAIN:
  - op_ready=0.
  - On mac_res_valid: res_data<=mac_res, res_valid[w]<=1, state=RESULT.
  - No timeout.
- RESULT:
  - res_valid is high for exactly this cycle.
  - gnt<=0, state=IDLE.
  - Minimum gap between consecutive bursts is 2 cycles (RESULT, then the IDLE arbitration cycle).
- mac_res_valid in any state other than DRAIN: result discarded, err[1] set, no other effect.
- err bits are cleared only by reset.
- No arithmetic is performed in this block. Operands and results pass through at full DATA_WIDTH, unmodified and unsigned-agnostic.

Test Plan:
- Single burst: req=01, 32 ops on ch0 with op_last on the 32nd; mac_ready=1; MAC returns 0x00000123 three cycles later. Required: gnt=01 one cycle after req; mac_first on op 1 only; mac_last on op 32; res_valid=01 with res_data=0x00000123 one cycle after mac_res_valid; gnt=00 the following cycle.
- Contention and fairness: req=11 held continuously, 4-op bursts each. Required: grant order ch0, ch1, ch0, ch1; no cycle with mac_valid from a non-granted channel.
- Backpressure: mac_ready toggles 1,0,1,0 during a burst. Required: op_ready follows mac_ready; exactly 4 transfers for 4 ops; mac_a/mac_b match the corresponding coefficient/sample sequence.
- Overrun: ch1 sends 33 ops with no op_last. Required: the 32nd transfer has mac_last=1 and err=01; state leaves GRANT; the 33rd op_ready is never asserted.
- Stray result: mac_res_valid pulses in IDLE. Required: err[1]=1, res_valid stays 0; a subsequent normal burst completes correctly.
- Reset mid-burst: assert reset low after 10 ops. Required: all outputs 0 immediately. After release with req=11, ch0 is granted first.
